memctl_burst_loader: RTL and testbench
======================================

Name: memctl_burst_loader

Overview:
- Parametrised successor to the fixed 512-sample ROM-to-RAM loader.
- On START_I, copies LEN_I words from a synchronous source memory into a circular destination buffer at one word per cycle.
- Handles configurable source read latency, base-address reload, abort, and a done pulse.
- Sits between the MP3 bitstream source ROM and the decoder input buffer.

Parameters:
DATA_W, 32, source/destination word width
SRC_AW, 15, source address width; source pointer wraps modulo 2^SRC_AW
DST_AW, 10, destination address width
DST_DEPTH, 512, circular destination depth (<= 2^DST_AW); pointer wraps DST_DEPTH-1 -> 0
LEN_W, 10, width of LEN_I (max burst 2^LEN_W-1)
SRC_LAT, 1, source read latency in cycles (1..4)

Ports:
CLOCK_I  in  1  clock, rising edge
RESETN_I  in  1  asynchronous active-low reset
START_I  in  1  start request, sampled in IDLE only
LEN_I  in  LEN_W  burst length in words, sampled with START_I
LOAD_I  in  1  when high with accepted START_I, reload both pointers from *_BASE_I
SRC_BASE_I  in  SRC_AW  source base for reload
DST_BASE_I  in  DST_AW  destination base for reload
ABORT_I  in  1  stop issuing reads; drain in-flight words
SRC_EN_O  out  1  source read enable
SRC_ADDR_O  out  SRC_AW  source read address
SRC_DATA_I  in  DATA_W  source data, valid SRC_LAT cycles after SRC_EN_O
DST_EN_O  out  1  destination enable (= DST_WE_O)
DST_WE_O  out  1  destination write strobe
DST_ADDR_O  out  DST_AW  destination write address
DST_DATA_O  out  DATA_W  destination write data (SRC_DATA_I passthrough)
BUSY_O  out  1  high from the cycle after START acceptance until the DONE cycle, inclusive
DONE_O  out  1  one-cycle completion pulse
CHECKSUM_O  out  32  running sum of written words (optional feature)

Behaviour:
- Reset:
  - state IDLE; all outputs 0.
  - src_ptr, dst_ptr, remaining count, valid pipe, checksum all 0.
  - Asserting reset mid-burst kills in-flight writes immediately; no write after reset asserts.
- States:
  - IDLE:
    - START_I && LEN_I!=0 -> ISSUE; LEN_I captured.
    - If LOAD_I: src_ptr <= SRC_BASE_I; dst_ptr <= DST_BASE_I, or 0 if DST_BASE_I >= DST_DEPTH.
    - Without LOAD_I, pointers continue from the previous burst.
    - START_I && LEN_I==0 -> DONE pulse next cycle; no memory access.
  - ISSUE:
    - SRC_EN_O=1, SRC_ADDR_O=src_ptr; src_ptr++ and remaining-- each cycle.
    - After LEN issues, or on ABORT_I -> DRAIN.
    - An ABORT_I cycle issues no read.
  - DRAIN: no reads; when valid pipe empty -> IDLE with DONE_O=1 for one cycle.
- Write path:
  - A valid shift register of depth SRC_LAT tracks issued reads.
  - DST_WE_O is asserted in the cycle SRC_DATA_I is valid (issue + SRC_LAT); DST_ADDR_O=dst_ptr, then dst_ptr++ with wrap at DST_DEPTH.
  - Exactly one write per issued read, in issue order, no gaps.
- Timing:
  - START accepted at edge k: first SRC_EN_O in cycle k+1, first write in cycle k+1+SRC_LAT.
  - DONE_O in the cycle after the last write.
  - BUSY_O low in IDLE otherwise.
- START_I while BUSY_O is ignored. ABORT_I in IDLE is ignored.
- ABORT_I and the last issue in the same cycle: the abort wins; no read is issued that cycle.
- LEN_I >= DST_DEPTH is legal; the destination overwrites circularly.

Optional Feature:
- MEMCTL_CHECKSUM_EN defined:
  - CHECKSUM_O clears on START acceptance.
  - Adds DST_DATA_O (modulo 2^32, low 32 bits if DATA_W>32, zero-extended if smaller) on every write.
  - Stable and valid while DONE_O is high and until the next START.
- Not defined: CHECKSUM_O tied to 0; no adder logic.

Test Plan:
1. Reset, START_I with LOAD_I=1, SRC_BASE=0, DST_BASE=0, LEN=512, SRC_LAT=1, ROM[i]=i -> 512 contiguous writes, DST[i]=i, first write 2 cycles after START edge, DONE_O one cycle after last write, BUSY_O high 514 cycles.
2. Two back-to-back START, LOAD_I=0, LEN=300 each, DST_DEPTH=512 -> second burst's source continues at 300; destination wraps 511->0 at the 212th word of burst 2.
3. SRC_LAT=3, LEN=4 -> writes in cycles k+4..k+7, DONE_O in k+8, data matches the issued addresses.
4. ABORT_I in the 5th ISSUE cycle, LEN=100, SRC_LAT=2 -> exactly 4 writes, no further SRC_EN_O, DONE_O after drain; START_I during BUSY is ignored.
5. LEN=0 -> no SRC_EN_O/DST_WE_O, DONE_O one cycle after START; pull RESETN_I low mid-burst -> all outputs 0 immediately, no further writes.
6. MEMCTL_CHECKSUM_EN, ROM[i]=i, LEN=512 -> CHECKSUM_O=130816 at DONE_O; without the macro, CHECKSUM_O=0.

Source files
------------

// File: rtl/memctl_burst_loader.sv
// memctl_burst_loader
// Copies a burst of LEN_I words from a synchronous source memory (read
// latency SRC_LAT cycles) into a circular destination buffer at one word per
// cycle. It sits between the MP3 bitstream source ROM and the decoder input
// buffer.
//
// Ports:
//   CLOCK_I, RESETN_I         clock (rising edge), asynchronous active-low reset
//   START_I, LEN_I, LOAD_I    burst request, length, pointer reload (IDLE only)
//   SRC_BASE_I, DST_BASE_I    reload values for the source/destination pointers
//   ABORT_I                   stop issuing reads, drain reads already in flight
//   SRC_EN_O, SRC_ADDR_O      source read port
//   SRC_DATA_I                source data, valid SRC_LAT cycles after SRC_EN_O
//   DST_EN_O, DST_WE_O        destination enable / write strobe (identical)
//   DST_ADDR_O, DST_DATA_O    destination write address / data
//   BUSY_O, DONE_O            busy window and one-cycle completion pulse
//   CHECKSUM_O                running 32-bit sum of the words written
//
// Build option: define MEMCTL_CHECKSUM_EN to enable the checksum accumulator.
// Without it CHECKSUM_O is tied to zero and no adder is built.
module memctl_burst_loader #(
  parameter int DATA_W    = 32,
  parameter int SRC_AW    = 15,
  parameter int DST_AW    = 10,
  parameter int DST_DEPTH = 512,
  parameter int LEN_W     = 10,
  parameter int SRC_LAT   = 1
) (
  input  logic              CLOCK_I,
  input  logic              RESETN_I,
  input  logic              START_I,
  input  logic [LEN_W-1:0]  LEN_I,
  input  logic              LOAD_I,
  input  logic [SRC_AW-1:0] SRC_BASE_I,
  input  logic [DST_AW-1:0] DST_BASE_I,
  input  logic              ABORT_I,
  output logic              SRC_EN_O,
  output logic [SRC_AW-1:0] SRC_ADDR_O,
  input  logic [DATA_W-1:0] SRC_DATA_I,
  output logic              DST_EN_O,
  output logic              DST_WE_O,
  output logic [DST_AW-1:0] DST_ADDR_O,
  output logic [DATA_W-1:0] DST_DATA_O,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic [31:0]       CHECKSUM_O
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [DST_AW:0]   DEPTH_EXT = (DST_AW+1)'(DST_DEPTH);
  localparam logic [DST_AW-1:0] DST_LAST  = DST_AW'(DST_DEPTH - 1);

  logic [1:0]         state_reg, state_next;
  logic [SRC_AW-1:0]  src_ptr_reg, src_ptr_next;
  logic [DST_AW-1:0]  dst_ptr_reg, dst_ptr_next;
  logic [LEN_W-1:0]   remain_reg, remain_next;
  logic [SRC_LAT-1:0] vpipe_reg, vpipe_next;
  logic               done_reg, done_next;
  logic               accept;
  logic               issue;
  logic               write;

  // The DONE cycle still counts as busy, so a START there is ignored too.
  assign accept = START_I && (state_reg == ST_IDLE) && !done_reg;
  // An abort cycle never issues, even if it coincides with the last read.
  assign issue  = (state_reg == ST_ISSUE) && !ABORT_I;
  // The oldest valid-pipe stage lines up with the cycle the source data arrives.
  assign write  = vpipe_reg[SRC_LAT-1];

  generate
    for (genvar gi = 0; gi < SRC_LAT; gi++) begin : g_vpipe
      if (gi == 0) begin : g_head
        assign vpipe_next[gi] = issue;
      end else begin : g_tail
        assign vpipe_next[gi] = vpipe_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    src_ptr_next = src_ptr_reg;
    dst_ptr_next = dst_ptr_reg;
    remain_next  = remain_reg;
    done_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (LOAD_I) begin
            src_ptr_next = SRC_BASE_I;
            // An out-of-range destination base restarts the ring at 0.
            dst_ptr_next = ({1'b0, DST_BASE_I} >= DEPTH_EXT) ? '0 : DST_BASE_I;
          end
          remain_next = LEN_I;
          if (LEN_I == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          src_ptr_next = src_ptr_reg + 1'b1;
          remain_next  = remain_reg - 1'b1;
        end
        if (ABORT_I || (remain_reg == LEN_W'(1))) begin
          // Skip DRAIN when nothing is left in flight (abort with an empty
          // pipe) so DONE still lands right after the last write.
          if (vpipe_next == '0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (vpipe_next == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Writes only happen while busy, so this never collides with a reload.
    if (write) begin
      dst_ptr_next = (dst_ptr_reg == DST_LAST) ? '0 : dst_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state_reg   <= ST_IDLE;
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      remain_reg  <= '0;
      vpipe_reg   <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      src_ptr_reg <= src_ptr_next;
      dst_ptr_reg <= dst_ptr_next;
      remain_reg  <= remain_next;
      vpipe_reg   <= vpipe_next;
      done_reg    <= done_next;
    end
  end

  // Address/data buses are gated so every output reads 0 outside an access.
  assign SRC_EN_O   = issue;
  assign SRC_ADDR_O = issue ? src_ptr_reg : '0;
  assign DST_WE_O   = write;
  assign DST_EN_O   = write;
  assign DST_ADDR_O = write ? dst_ptr_reg : '0;
  assign DST_DATA_O = write ? SRC_DATA_I : '0;
  assign BUSY_O     = (state_reg != ST_IDLE) || done_reg;
  assign DONE_O     = done_reg;

`ifdef MEMCTL_CHECKSUM_EN
  logic [31:0] csum_reg;
  logic [31:0] word32;

  if (DATA_W >= 32) begin : g_csum_trunc
    assign word32 = SRC_DATA_I[31:0];
  end else begin : g_csum_zext
    assign word32 = {{(32-DATA_W){1'b0}}, SRC_DATA_I};
  end

  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      csum_reg <= '0;
    end else if (accept) begin
      csum_reg <= '0;
    end else if (write) begin
      csum_reg <= csum_reg + word32;
    end
  end

  assign CHECKSUM_O = csum_reg;
`else
  assign CHECKSUM_O = 32'd0;
`endif

endmodule

// File: tb/tb_memctl_burst_loader.sv
// Testbench for memctl_burst_loader. Three instances with SRC_LAT = 1, 2, 3
// share the same stimulus; each has its own source ROM model (ROM[a] = a).
// Expected writes and DONE pulses are pushed to a scoreboard when a burst is
// started and compared as each instance produces them.
module tb_memctl_burst_loader;

  localparam int NL    = 3;
  localparam int DW    = 32;
  localparam int SAW   = 15;
  localparam int DAW   = 10;
  localparam int DEPTH = 512;
  localparam int LW    = 10;
`ifdef MEMCTL_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start, load, abort;
  logic [LW-1:0]  len;
  logic [SAW-1:0] src_base;
  logic [DAW-1:0] dst_base;

  logic [NL-1:0]  src_en, dst_en, dst_we, busy, done;
  logic [SAW-1:0] src_addr [NL];
  logic [DAW-1:0] dst_addr [NL];
  logic [DW-1:0]  src_data [NL];
  logic [DW-1:0]  dst_data [NL];
  logic [31:0]    csum     [NL];

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      logic [DW-1:0] rpipe [gi+1];

      memctl_burst_loader #(
        .DATA_W(DW), .SRC_AW(SAW), .DST_AW(DAW), .DST_DEPTH(DEPTH),
        .LEN_W(LW), .SRC_LAT(gi + 1)
      ) u_dut (
        .CLOCK_I(clk), .RESETN_I(rst_n), .START_I(start), .LEN_I(len),
        .LOAD_I(load), .SRC_BASE_I(src_base), .DST_BASE_I(dst_base),
        .ABORT_I(abort), .SRC_EN_O(src_en[gi]), .SRC_ADDR_O(src_addr[gi]),
        .SRC_DATA_I(src_data[gi]), .DST_EN_O(dst_en[gi]), .DST_WE_O(dst_we[gi]),
        .DST_ADDR_O(dst_addr[gi]), .DST_DATA_O(dst_data[gi]), .BUSY_O(busy[gi]),
        .DONE_O(done[gi]), .CHECKSUM_O(csum[gi])
      );

      // Source ROM with latency gi+1; garbage when not read.
      always @(posedge clk) begin
        rpipe[0] <= src_en[gi] ? DW'(src_addr[gi]) : 32'hDEAD_BEEF;
        for (int j = 1; j <= gi; j++) rpipe[j] <= rpipe[j-1];
      end
      assign src_data[gi] = rpipe[gi];
    end
  endgenerate

  typedef struct { int base; int addr; int data; } wr_t;
  typedef struct { int base; bit lat_dep; int unsigned csum; } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    wr_idx[NL], done_idx[NL], src_cnt[NL], busy_cnt[NL], post_act[NL];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    sb_on = 1'b0;
  int    src_m = 0, dst_m = 0, exp_src = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pending_cnt();
    int p = 0;
    for (int l = 0; l < NL; l++) p += exp_done.size() - done_idx[l];
    return p;
  endfunction

  // Per-cycle monitor, sampled at the falling edge.
  task automatic monitor_cycle();
    for (int l = 0; l < NL; l++) begin
      int lat;
      lat = l + 1;
      if (src_en[l]) src_cnt[l]++;
      if (busy[l]) busy_cnt[l]++;
      check($sformatf("L%0d dst_en_eq_we c%0d", lat, cyc), dst_en[l], dst_we[l]);
      if (!sb_on) begin
        if (dst_we[l] || src_en[l]) post_act[l]++;
      end else begin
        if (dst_we[l]) begin
          if (wr_idx[l] < exp_wr.size()) begin
            wr_t e;
            e = exp_wr[wr_idx[l]];
            check($sformatf("L%0d wr%0d cycle", lat, wr_idx[l]), cyc, e.base + lat);
            check($sformatf("L%0d wr%0d addr", lat, wr_idx[l]), dst_addr[l], e.addr);
            check($sformatf("L%0d wr%0d data", lat, wr_idx[l]), dst_data[l], e.data);
            wr_idx[l]++;
          end else begin
            check($sformatf("L%0d extra_write c%0d", lat, cyc), dst_we[l], 1'b0);
          end
        end
        if (done[l]) begin
          if (done_idx[l] < exp_done.size()) begin
            done_t d;
            d = exp_done[done_idx[l]];
            check($sformatf("L%0d done%0d cycle", lat, done_idx[l]), cyc,
                  d.lat_dep ? d.base + lat : d.base);
            check($sformatf("L%0d done%0d busy", lat, done_idx[l]), busy[l], 1'b1);
            check($sformatf("L%0d done%0d checksum", lat, done_idx[l]), csum[l], d.csum);
            done_idx[l]++;
          end else begin
            check($sformatf("L%0d extra_done c%0d", lat, cyc), done[l], 1'b0);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called in the cycle START_I is driven; nabort>0 means abort after nabort reads.
  task automatic push_burst(input int n, input bit ld, input int sb, input int db, input int nabort);
    int nis;
    int unsigned sum;
    wr_t w;
    done_t d;
    sum = 0;
    if (ld) begin
      src_m = sb;
      dst_m = (db >= DEPTH) ? 0 : db;
    end
    nis = (nabort > 0) ? nabort : n;
    for (int i = 0; i < nis; i++) begin
      w.base = cyc + 1 + i;
      w.addr = dst_m;
      w.data = src_m;
      exp_wr.push_back(w);
      sum += src_m;
      src_m = (src_m + 1) % (1 << SAW);
      dst_m = (dst_m + 1) % DEPTH;
    end
    exp_src += nis;
    d.base    = cyc + 1 + nis;
    d.lat_dep = (nis != 0);
    d.csum    = CSUM_ON ? sum : 0;
    exp_done.push_back(d);
  endtask

  task automatic drive_start(input int n, input bit ld, input int sb, input int db);
    start    = 1'b1;
    len      = LW'(n);
    load     = ld;
    src_base = SAW'(sb);
    dst_base = DAW'(db);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (pending_cnt() != 0 && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("burst_done_timeout c%0d", cyc), pending_cnt(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("%s L%0d src_en", tag, l + 1), src_en[l], 1'b0);
      check($sformatf("%s L%0d src_addr", tag, l + 1), src_addr[l], 0);
      check($sformatf("%s L%0d dst_we", tag, l + 1), dst_we[l], 1'b0);
      check($sformatf("%s L%0d dst_en", tag, l + 1), dst_en[l], 1'b0);
      check($sformatf("%s L%0d dst_addr", tag, l + 1), dst_addr[l], 0);
      check($sformatf("%s L%0d dst_data", tag, l + 1), dst_data[l], 0);
      check($sformatf("%s L%0d busy", tag, l + 1), busy[l], 1'b0);
      check($sformatf("%s L%0d done", tag, l + 1), done[l], 1'b0);
      check($sformatf("%s L%0d checksum", tag, l + 1), csum[l], 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load = 1'b0; abort = 1'b0;
    len = '0; src_base = '0; dst_base = '0;
    @(posedge clk);
    #1;
    cyc = 0;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    sb_on = 1'b1;

    // ABORT_I while idle is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // 512-word burst from base 0, ROM[i]=i
    for (int l = 0; l < NL; l++) busy_cnt[l] = 0;
    push_burst(512, 1'b1, 0, 0, 0);
    drive_start(512, 1'b1, 0, 0);
    tick();
    start = 1'b0; load = 1'b0;
    wait_done(700);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("L%0d busy_cycles_512", l + 1), busy_cnt[l], 513 + l + 1);
      check($sformatf("L%0d busy_low_idle", l + 1), busy[l], 1'b0);
    end

    // Two back-to-back 300-word bursts; second continues pointers and wraps dst
    push_burst(300, 1'b1, 0, 0, 0);
    drive_start(300, 1'b1, 0, 0);
    tick();
    start = 1'b0; load = 1'b0;
    wait_done(400);
    push_burst(300, 1'b0, 0, 0, 0);
    drive_start(300, 1'b0, 0, 0);
    tick();
    start = 1'b0;
    wait_done(400);

    // Reload with source near the top (wraps) and out-of-range dst base (-> 0)
    push_burst(5, 1'b1, 32766, 700, 0);
    drive_start(5, 1'b1, 32766, 700);
    tick();
    start = 1'b0; load = 1'b0;
    wait_done(20);

    // Short burst, latency dependence visible across lanes
    push_burst(4, 1'b1, 100, 10, 0);
    drive_start(4, 1'b1, 100, 10);
    tick();
    start = 1'b0; load = 1'b0;
    wait_done(20);

    // Abort in the 5th ISSUE cycle of a 100-word burst; START while busy ignored
    push_burst(100, 1'b1, 1000, 500, 4);
    drive_start(100, 1'b1, 1000, 500);
    tick();
    start = 1'b0; load = 1'b0;
    tick();
    drive_start(7, 1'b1, 5, 5);
    tick();
    start = 1'b0; load = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(20);
    for (int l = 0; l < NL; l++)
      check($sformatf("L%0d src_reads_after_abort", l + 1), src_cnt[l], exp_src);

    // Abort coinciding with the last issue: the abort wins
    push_burst(3, 1'b0, 0, 0, 2);
    drive_start(3, 1'b0, 0, 0);
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(20);

    // Zero-length request: DONE next cycle, no memory access
    push_burst(0, 1'b0, 0, 0, 0);
    drive_start(0, 1'b0, 0, 0);
    tick();
    start = 1'b0;
    wait_done(10);
    tick();

    for (int l = 0; l < NL; l++) begin
      check($sformatf("L%0d all_writes_seen", l + 1), wr_idx[l], exp_wr.size());
      check($sformatf("L%0d all_dones_seen", l + 1), done_idx[l], exp_done.size());
      check($sformatf("L%0d total_src_reads", l + 1), src_cnt[l], exp_src);
    end

    // Reset asserted mid-burst: outputs drop at once, no later activity
    sb_on = 1'b0;
    drive_start(50, 1'b1, 0, 0);
    tick();
    start = 1'b0; load = 1'b0;
    repeat (5) tick();
    check("writes_active_before_reset", dst_we, {NL{1'b1}});
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_burst_reset");
    for (int l = 0; l < NL; l++) post_act[l] = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    for (int l = 0; l < NL; l++)
      check($sformatf("L%0d activity_after_reset", l + 1), post_act[l], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
